// File: rtl/pifo_access_sched.sv
// pifo_access_sched: arbitrates NUM_PORTS enqueue sources and one dequeue
// consumer onto a single pipelined PIFO port, with pop spacing and a
// clear/drain sequence.
module pifo_access_sched #(
    parameter int unsigned NUM_PORTS    = 4,
    parameter int unsigned PRIO_WIDTH   = 8,
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned POP_GAP      = 1,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic [NUM_PORTS-1:0]             i__enq_valid,
    input  logic [NUM_PORTS*PRIO_WIDTH-1:0]  i__enq_prio,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0]  i__enq_data,
    output logic [NUM_PORTS-1:0]             o__enq_ready,
    input  logic                             i__deq_req,
    output logic                             o__deq_valid,
    output logic [PRIO_WIDTH-1:0]            o__deq_prio,
    output logic [DATA_WIDTH-1:0]            o__deq_data,
    input  logic                             i__clear_req,
    output logic                             o__busy,
    output logic [CNT_WIDTH-1:0]             o__push_count,
    output logic [CNT_WIDTH-1:0]             o__pop_count,
    output logic                             o__pifo_in_valid,
    output logic [PRIO_WIDTH-1:0]            o__pifo_in_prio,
    output logic [DATA_WIDTH-1:0]            o__pifo_in_data,
    input  logic                             i__pifo_in_ready,
    input  logic                             i__pifo_out_valid,
    input  logic [PRIO_WIDTH-1:0]            i__pifo_out_prio,
    input  logic [DATA_WIDTH-1:0]            i__pifo_out_data,
    output logic                             o__pifo_out_ready,
    output logic                             o__pifo_clear
);

    localparam int unsigned PTR_W = $clog2(NUM_PORTS);
    localparam int unsigned GAP_W = (POP_GAP < 1) ? 1 : $clog2(POP_GAP + 1);
    localparam int unsigned DRN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);

    localparam logic OP_PUSH = 1'b0;
    localparam logic OP_POP  = 1'b1;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [DRN_W-1:0]       drain_q, drain_d;
    logic [PTR_W-1:0]       rr_ptr;
    logic                   last_op;
    logic [GAP_W-1:0]       gap_cnt;

    logic                   grant_found;
    logic [PTR_W-1:0]       grant_idx;
    logic [PTR_W-1:0]       cand_idx;
    logic                   run_ok;
    logic                   push_cand;
    logic                   pop_cand;
    logic                   push_fire;
    logic                   pop_fire;

    logic [PRIO_WIDTH-1:0]  enq_prio_arr [NUM_PORTS];
    logic [DATA_WIDTH-1:0]  enq_data_arr [NUM_PORTS];

    // Unpack the flat per-port buses into arrays indexed by port
    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_unpack
        assign enq_prio_arr[p] = i__enq_prio[p*PRIO_WIDTH +: PRIO_WIDTH];
        assign enq_data_arr[p] = i__enq_data[p*DATA_WIDTH +: DATA_WIDTH];
    end

    // Round-robin search: first valid port at or after rr_ptr
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand_idx    = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            cand_idx = PTR_W'((32'(rr_ptr) + i) % NUM_PORTS);
            if (!grant_found && i__enq_valid[cand_idx]) begin
                grant_found = 1'b1;
                grant_idx   = cand_idx;
            end
        end
    end

    // Slot selection, PIFO-side outputs and next-state logic
    always_comb begin
        state_d           = state_q;
        drain_d           = drain_q;
        o__enq_ready      = '0;
        o__pifo_in_valid  = 1'b0;
        o__pifo_in_prio   = '0;
        o__pifo_in_data   = '0;
        o__pifo_out_ready = 1'b0;

        run_ok    = (state_q == ST_RUN) && !reset;
        push_cand = run_ok && grant_found && i__pifo_in_ready;
        pop_cand  = run_ok && i__deq_req && i__pifo_out_valid && (gap_cnt == '0);
        // On a tie, alternate against the last performed operation
        push_fire = push_cand && (!pop_cand || (last_op == OP_POP));
        pop_fire  = pop_cand && !push_fire;

        if (push_fire) begin
            o__enq_ready[grant_idx] = 1'b1;
            o__pifo_in_valid        = 1'b1;
            o__pifo_in_prio         = enq_prio_arr[grant_idx];
            o__pifo_in_data         = enq_data_arr[grant_idx];
        end
        if (pop_fire) begin
            o__pifo_out_ready = 1'b1;
        end

        case (state_q)
            ST_RUN: begin
                if (i__clear_req) begin
                    state_d = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                state_d = ST_DRAIN;
                drain_d = DRN_W'(DRAIN_CYCLES - 1);
            end
            ST_DRAIN: begin
                if (drain_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    drain_d = drain_q - DRN_W'(1);
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Status outputs decoded from the state register
    assign o__busy       = (state_q != ST_RUN);
    assign o__pifo_clear = (state_q == ST_CLEAR);

    // State and drain counter register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_RUN;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
        end
    end

    // Arbitration history, pop spacing and round-robin pointer
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr  <= '0;
            last_op <= OP_POP;
            gap_cnt <= '0;
        end else begin
            if (push_fire) begin
                rr_ptr  <= PTR_W'((32'(grant_idx) + 1) % NUM_PORTS);
                last_op <= OP_PUSH;
            end else if (pop_fire) begin
                last_op <= OP_POP;
            end
            if (pop_fire) begin
                gap_cnt <= GAP_W'(POP_GAP);
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GAP_W'(1);
            end
        end
    end

    // Dequeue result register: one-cycle pulse after each pop
    always_ff @(posedge clk) begin
        if (reset) begin
            o__deq_valid <= 1'b0;
            o__deq_prio  <= '0;
            o__deq_data  <= '0;
        end else begin
            o__deq_valid <= pop_fire;
            if (pop_fire) begin
                o__deq_prio <= i__pifo_out_prio;
                o__deq_data <= i__pifo_out_data;
            end
        end
    end

    // Push/pop statistics, cleared by a flush
    always_ff @(posedge clk) begin
        if (reset || (state_q == ST_CLEAR)) begin
            o__push_count <= '0;
            o__pop_count  <= '0;
        end else begin
            if (push_fire) begin
                o__push_count <= o__push_count + CNT_WIDTH'(1);
            end
            if (pop_fire) begin
                o__pop_count <= o__pop_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
